// File: rtl/boost_pwm_ctrl.sv
// Boost converter PWM sequencer: soft-start, slew-limited duty tracking, duty ceiling
// and latched fault shutdown, producing one gate command for the dead-time stage.
module boost_pwm_ctrl #(
    parameter int CNT_W    = 10,
    parameter int PERIOD   = 999,
    parameter int DUTY_MAX = 900,
    parameter int SS_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] duty_cmd,
    input  logic             fault_in,
    input  logic             fault_clr,
    output logic             pwm_out,
    output logic             period_start,
    output logic [CNT_W-1:0] duty_eff,
    output logic [1:0]       state,
    output logic             fault_latched
);

    // state     | meaning
    // IDLE      | converter off, duty held at zero
    // SOFTSTART | duty ramps by SS_STEP per period toward target
    // RUN       | duty tracks target; increases slew-limited, decreases immediate
    // FAULT     | gate off, waiting for fault_clr with fault_in and en both low
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        RUN       = 2'd2,
        FAULT     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] PER_TC = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] DMAX   = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W:0]   STEP   = (CNT_W+1)'(SS_STEP);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] duty_d;
    logic [CNT_W-1:0] target;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] stepped;
    logic             boundary;

    assign boundary = (cnt == PER_TC);
    assign target   = (duty_cmd > DMAX) ? DMAX : duty_cmd;
    // One extra bit so the ramp can never wrap past the ceiling.
    assign sum      = {1'b0, duty_eff} + STEP;
    assign stepped  = (sum > {1'b0, target}) ? target : sum[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        duty_d  = duty_eff;
        if (fault_in) begin
            state_d = FAULT;
            duty_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (en) state_d = SOFTSTART;
                end
                SOFTSTART: begin
                    if (!en) begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end else if (boundary) begin
                        duty_d = stepped;
                        if (stepped == target) state_d = RUN;
                    end
                end
                RUN: begin
                    // min(duty+step, target) also covers an immediate decrease.
                    if (!en) begin
                        state_d = IDLE;
                        duty_d  = '0;
                    end else if (boundary) begin
                        duty_d = stepped;
                    end
                end
                FAULT: begin
                    duty_d = '0;
                    if (fault_clr && !en) state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt           <= '0;
            duty_eff      <= '0;
            pwm_out       <= 1'b0;
            period_start  <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt           <= boundary ? '0 : cnt + 1'b1;
            duty_eff      <= duty_d;
            period_start  <= boundary;
            pwm_out       <= ((state_q == SOFTSTART) || (state_q == RUN)) && !fault_in
                             && en && (cnt < duty_eff);
            fault_latched <= (state_d == FAULT);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_boost_pwm_ctrl.sv
// Bench for boost_pwm_ctrl: directed vector table plus randomized traffic, all
// checked every cycle against a behavioural model of the sequencing rules.
module tb_boost_pwm_ctrl;

    localparam int CNT_W    = 10;
    localparam int PERIOD   = 9;
    localparam int DUTY_MAX = 8;
    localparam int SS_STEP  = 2;

    localparam int S_IDLE = 0, S_SS = 1, S_RUN = 2, S_FAULT = 3;

    logic             clk = 1'b0;
    logic             rst, en, fault_in, fault_clr;
    logic [CNT_W-1:0] duty_cmd;
    logic             pwm_out, period_start, fault_latched;
    logic [CNT_W-1:0] duty_eff;
    logic [1:0]       state;

    int checks = 0;
    int failures = 0;

    // reference model state
    int m_cnt, m_duty, m_st;
    bit m_pwm, m_ps, m_flt;

    boost_pwm_ctrl #(
        .CNT_W(CNT_W), .PERIOD(PERIOD), .DUTY_MAX(DUTY_MAX), .SS_STEP(SS_STEP)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .duty_cmd(duty_cmd),
        .fault_in(fault_in), .fault_clr(fault_clr),
        .pwm_out(pwm_out), .period_start(period_start), .duty_eff(duty_eff),
        .state(state), .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_edge();
        bit bnd;
        int tgt, nd;
        if (rst) begin
            m_cnt = 0; m_duty = 0; m_st = S_IDLE;
            m_pwm = 0; m_ps = 0; m_flt = 0;
            return;
        end
        bnd = (m_cnt == PERIOD);
        tgt = (int'(duty_cmd) > DUTY_MAX) ? DUTY_MAX : int'(duty_cmd);
        m_pwm = (m_st == S_SS || m_st == S_RUN) && !fault_in && en && (m_cnt < m_duty);
        m_ps = bnd;
        m_cnt = bnd ? 0 : m_cnt + 1;
        if (fault_in) begin
            m_st = S_FAULT; m_duty = 0;
        end else if (m_st == S_FAULT) begin
            if (fault_clr && !en) m_st = S_IDLE;
        end else if (!en) begin
            m_st = S_IDLE; m_duty = 0;
        end else if (m_st == S_IDLE) begin
            m_st = S_SS;
        end else if (bnd) begin
            if (m_st == S_SS) begin
                nd = (m_duty + SS_STEP < tgt) ? m_duty + SS_STEP : tgt;
                m_duty = nd;
                if (nd == tgt) m_st = S_RUN;
            end else begin
                if (tgt <= m_duty) m_duty = tgt;
                else m_duty = (m_duty + SS_STEP < tgt) ? m_duty + SS_STEP : tgt;
            end
        end
        m_flt = (m_st == S_FAULT);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pwm_out", int'(pwm_out), int'(m_pwm));
        chk("period_start", int'(period_start), int'(m_ps));
        chk("duty_eff", int'(duty_eff), m_duty);
        chk("state", int'(state), m_st);
        chk("fault_latched", int'(fault_latched), int'(m_flt));
    endtask

    typedef struct {
        bit rst;
        bit en;
        int duty;
        bit fin;
        bit fclr;
        int cyc;
        int exp_st;
        int exp_duty;
        bit exp_flt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // rst en duty fin fclr cyc | state duty flt  (cnt starts at 0 after reset)
        vecs.push_back('{0, 1,  6, 0, 0,  1, S_SS,    0, 0}); // enter soft-start
        vecs.push_back('{0, 1,  6, 0, 0,  9, S_SS,    2, 0});
        vecs.push_back('{0, 1,  6, 0, 0, 10, S_SS,    4, 0});
        vecs.push_back('{0, 1,  6, 0, 0, 10, S_RUN,   6, 0});
        vecs.push_back('{0, 1,  6, 0, 0, 10, S_RUN,   6, 0});
        vecs.push_back('{0, 1, 15, 0, 0, 10, S_RUN,   8, 0}); // clamp at DUTY_MAX
        vecs.push_back('{0, 1, 15, 0, 0, 10, S_RUN,   8, 0});
        vecs.push_back('{0, 1,  8, 0, 0,  4, S_RUN,   8, 0});
        vecs.push_back('{0, 1,  1, 0, 0,  6, S_RUN,   1, 0}); // mid-period decrease
        vecs.push_back('{0, 1,  1, 0, 0, 10, S_RUN,   1, 0});
        vecs.push_back('{0, 1,  1, 0, 0,  3, S_RUN,   1, 0});
        vecs.push_back('{0, 1,  1, 1, 0,  1, S_FAULT, 0, 1}); // fault at cnt=3
        vecs.push_back('{0, 1,  1, 0, 1,  3, S_FAULT, 0, 1}); // clr ignored with en=1
        vecs.push_back('{0, 0,  1, 0, 0,  2, S_FAULT, 0, 1});
        vecs.push_back('{0, 0,  1, 0, 1,  1, S_IDLE,  0, 0});
        vecs.push_back('{0, 1,  6, 0, 0,  1, S_SS,    0, 0}); // restart from zero
        vecs.push_back('{0, 1,  6, 0, 0,  9, S_SS,    2, 0});
        vecs.push_back('{0, 1,  6, 0, 0, 10, S_SS,    4, 0});
        vecs.push_back('{0, 1,  6, 0, 0,  2, S_SS,    4, 0});
        vecs.push_back('{0, 0,  6, 0, 0,  1, S_IDLE,  0, 0}); // en drop at cnt=2
        vecs.push_back('{0, 0,  6, 0, 0, 10, S_IDLE,  0, 0});
        vecs.push_back('{0, 1,  3, 0, 0,  1, S_SS,    0, 0});
        vecs.push_back('{0, 1,  3, 0, 0,  6, S_SS,    2, 0});
        vecs.push_back('{0, 1,  3, 0, 0, 10, S_RUN,   3, 0});
        vecs.push_back('{0, 1,  3, 0, 0,  5, S_RUN,   3, 0});
        vecs.push_back('{1, 1,  3, 0, 0,  1, S_IDLE,  0, 0}); // reset at cnt=5
        vecs.push_back('{0, 0,  3, 0, 0, 10, S_IDLE,  0, 0});
        vecs.push_back('{0, 1,  0, 0, 0,  1, S_SS,    0, 0}); // zero target
        vecs.push_back('{0, 1,  0, 0, 0, 10, S_RUN,   0, 0});
        vecs.push_back('{0, 1,  0, 1, 1,  1, S_FAULT, 0, 1}); // clr with fault_in high
        vecs.push_back('{0, 0,  0, 0, 1,  1, S_IDLE,  0, 0});
        vecs.push_back('{0, 1,  5, 1, 0,  1, S_FAULT, 0, 1}); // en and fault together in IDLE

        rst = 1'b1; en = 1'b0; fault_in = 1'b0; fault_clr = 1'b0; duty_cmd = '0;
        step();
        step();
        chk("reset_state", int'(state), S_IDLE);
        chk("reset_pwm", int'(pwm_out), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; en = vecs[i].en; duty_cmd = CNT_W'(vecs[i].duty);
            fault_in = vecs[i].fin; fault_clr = vecs[i].fclr;
            for (int c = 0; c < vecs[i].cyc; c++) step();
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_st);
            chk($sformatf("vec%0d_duty", i), int'(duty_eff), vecs[i].exp_duty);
            chk($sformatf("vec%0d_flt", i), int'(fault_latched), int'(vecs[i].exp_flt));
        end

        // Randomized traffic against the model.
        rst = 1'b0; fault_in = 1'b0; fault_clr = 1'b0; en = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 19) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) duty_cmd = CNT_W'($urandom_range(0, 14));
            if (fault_in) fault_in = ($urandom_range(0, 2) == 0);
            else fault_in = ($urandom_range(0, 59) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
